// File: rtl/logicnet_lut_layer_pipe.sv
// Pipelined LogicNets layer of runtime-loadable truth-table neurons.
// Two register stages with valid/ready stream and a drain-then-load config port.
module logicnet_lut_layer_pipe #(
  parameter  int NUM_NEURONS = 4,
  parameter  int FANIN       = 3,
  parameter  int IN_BITS     = 2,
  parameter  int OUT_BITS    = 2,
  localparam int ADDR_W      = FANIN * IN_BITS,
  localparam int NID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_req,
  output logic                            cfg_ack,
  input  logic                            cfg_we,
  input  logic [NID_W-1:0]                cfg_neuron,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [NID_W:0]  NN_W  = (NID_W + 1)'(NUM_NEURONS);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CFG
  } state_e;

  state_e state_q, state_d;

  logic                            s1_valid_q, s1_valid_d;
  logic [NUM_NEURONS*ADDR_W-1:0]   s1_data_q, s1_data_d;
  logic                            s2_valid_q, s2_valid_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [NUM_NEURONS*OUT_BITS-1:0] lut_rd;

  logic [OUT_BITS-1:0] tbl_q [NUM_NEURONS][DEPTH];

  logic s2_adv, s1_adv, in_fire, cfg_wr;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = (state_q == RUN) && s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign cfg_ack   = (state_q == CFG);

  assign cfg_wr = (state_q == CFG) && cfg_we && ({1'b0, cfg_neuron} < NN_W);

  // Asynchronous table read of the S1 address, captured by S2.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_rd
    assign lut_rd[n*OUT_BITS +: OUT_BITS] =
      tbl_q[n][s1_data_q[n*ADDR_W +: ADDR_W]];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cfg_req) state_d = DRAIN;
      DRAIN: begin
        if (!cfg_req)                       state_d = RUN;
        else if (!s1_valid_q && !s2_valid_q) state_d = CFG;
      end
      CFG:     if (!cfg_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) s1_data_d = in_data;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = lut_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
    end
  end

  // Table is RAM: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (cfg_wr) tbl_q[cfg_neuron][cfg_addr] <= cfg_data;
  end

endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// Randomised bench for logicnet_lut_layer_pipe.
// Reference: per-neuron table arrays plus an expected-output queue.
module tb_logicnet_lut_layer_pipe;

  localparam int NN = 4;
  localparam int AW = 6;
  localparam int OB = 2;
  localparam int NW = 2;
  localparam int DW = NN * AW;
  localparam int OW = NN * OB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          cfg_req = 1'b0;
  logic          cfg_ack;
  logic          cfg_we = 1'b0;
  logic [NW-1:0] cfg_neuron = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [OB-1:0] cfg_data = '0;

  logicnet_lut_layer_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data)
  );

  always #5 clk = ~clk;

  logic [OB-1:0] mtbl [NN][64];
  logic [OW-1:0] exp_q [$];
  int            nchk = 0;
  int            npass = 0;
  bit            mode_cfg = 1'b0;
  logic [DW-1:0] wa, wb;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [OW-1:0] ref_lut(logic [DW-1:0] a);
    logic [OW-1:0] r;
    logic [AW-1:0] ad;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      ad = a[n*AW +: AW];
      r[n*OB +: OB] = mtbl[n][ad];
    end
    return r;
  endfunction

  task automatic tick();
    bit            inf, outf, hold;
    logic [OW-1:0] held;
    #1;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    hold = out_valid && !out_ready;
    held = out_data;
    if (inf) exp_q.push_back(ref_lut(in_data));
    if (outf) begin
      if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
      else chk("out_data", out_data, exp_q.pop_front());
    end
    if (mode_cfg && cfg_we) mtbl[cfg_neuron][cfg_addr] = cfg_data;
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_v", out_valid, 1);
      chk("hold_d", out_data, held);
    end
  endtask

  task automatic cfg_enter(int maxc);
    int k;
    k = 0;
    cfg_req = 1'b1;
    while (!cfg_ack && k < 40) begin
      tick();
      k++;
    end
    chk("cfg_ack", cfg_ack, 1);
    chk("cfg_ack_lat", (k <= maxc), 1);
    cfg_we = 1'b0;
    mode_cfg = 1'b1;
  endtask

  task automatic cfg_write(int n, int a, logic [OB-1:0] d);
    cfg_we = 1'b1;
    cfg_neuron = NW'(n);
    cfg_addr = AW'(a);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_exit(bit we, int n, int a, logic [OB-1:0] d);
    cfg_req = 1'b0;
    cfg_we = we;
    cfg_neuron = NW'(n);
    cfg_addr = AW'(a);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    mode_cfg = 1'b0;
    chk("cfg_exit_ack", cfg_ack, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 50) begin
      tick();
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic stream(int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = DW'($urandom);
      tick();
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a pending input word.
    in_valid = 1'b1;
    in_data = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ov", out_valid, 0);

    // Load every table entry, then the two directed entries.
    cfg_enter(2);
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < 64; a++)
        cfg_write(n, a, OB'($urandom));
    cfg_write(0, 12, 2'b01);
    cfg_write(0, 10, 2'b11);
    cfg_exit(1'b0, 0, 0, 2'b00);

    // Two-cycle latency of the first word.
    in_data = DW'($urandom);
    in_data[AW-1:0] = 6'b001100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat1_ov", out_valid, 0);
    tick();
    chk("lat2_ov", out_valid, 1);
    chk("lat2_n0", out_data[OB-1:0], 2'b01);
    in_data[AW-1:0] = 6'b001010;
    in_valid = 1'b1;
    tick();
    drain();

    // Back-to-back words at full rate.
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8);
      in_data = DW'($urandom);
      if (k < 8) chk("b2b_rdy", in_ready, 1);
      tick();
      chk("b2b_ov", out_valid, (k >= 1 && k <= 8));
    end
    drain();

    // Alternating backpressure.
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data = DW'($urandom);
      out_ready = (k % 2 == 0);
      tick();
    end
    drain();

    stream(300);

    // Config request with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'($urandom);
    wa = in_data;
    tick();
    in_data = DW'($urandom);
    wb = in_data;
    tick();
    in_valid = 1'b0;
    cfg_req = 1'b1;
    cfg_we = 1'b1;
    cfg_neuron = '0;
    cfg_addr = wa[AW-1:0];
    cfg_data = ~mtbl[0][wa[AW-1:0]];
    tick();
    chk("drain_rdy", in_ready, 0);
    out_ready = 1'b1;
    cfg_enter(8);
    chk("drain_done", exp_q.size(), 0);
    chk("drain_ov", out_valid, 0);
    cfg_exit(1'b0, 0, 0, 2'b00);
    in_valid = 1'b1;
    in_data = wa;
    tick();
    in_data = wb;
    tick();
    drain();

    // Single entry on neuron 3; neighbours cleared at that address.
    cfg_enter(2);
    cfg_write(0, 63, 2'b00);
    cfg_write(1, 63, 2'b00);
    cfg_write(2, 63, 2'b00);
    cfg_exit(1'b1, 3, 63, 2'b10);
    in_data = '1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("n3_only", out_data, 8'h80);
    drain();

    // Reset during CFG.
    cfg_enter(2);
    cfg_write(1, 5, OB'($urandom));
    rst = 1'b1;
    cfg_req = 1'b0;
    mode_cfg = 1'b0;
    #2;
    chk("rstcfg_ack", cfg_ack, 0);
    chk("rstcfg_ov", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rstcfg_ack2", cfg_ack, 0);

    // Reset with a stalled, full pipeline.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'($urandom);
    tick();
    in_data = DW'($urandom);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rststr_ov", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("rststr_rdy", in_ready, 1);
    chk("rststr_ov2", out_valid, 0);

    // Tables survive reset.
    in_data = '0;
    in_data[AW +: AW] = 6'd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    stream(100);

    chk("final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
